// File: rtl/pdt_boxcar_avg_if.sv
// Bus between the lock-in multiplier back end and its consumer.
//   pdt_i     : signed product from the upstream multiplier (2R bits)
//   ce_i      : sample-valid, issued alongside the multiplier operands
//   restart_i : abort the current window, issued alongside the operands
//   tau_i     : log2 window length, clamped to TAU_MAX by the consumer
//   out_o     : signed averaged result
//   valid_o   : one-cycle strobe when out_o updates
//   sat_o     : out_o was clamped
//   cnt_o     : samples accumulated in the current window
// slave modport is the averager, master modport is the driver.
interface pdt_boxcar_avg_if #(
   parameter int R       = 14,
   parameter int TAU_MAX = 10,
   parameter int OUT_W   = 16
);
   localparam int TW = $clog2(TAU_MAX + 1);

   logic signed [2*R-1:0]   pdt_i;
   logic                    ce_i;
   logic                    restart_i;
   logic [TW-1:0]           tau_i;
   logic signed [OUT_W-1:0] out_o;
   logic                    valid_o;
   logic                    sat_o;
   logic [TAU_MAX:0]        cnt_o;

   modport master (
      output pdt_i, ce_i, restart_i, tau_i,
      input  out_o, valid_o, sat_o, cnt_o
   );

   modport slave (
      input  pdt_i, ce_i, restart_i, tau_i,
      output out_o, valid_o, sat_o, cnt_o
   );
endinterface

// File: rtl/pdt_boxcar_avg.sv
// Lock-in demodulation back end: boxcar average of the multiplier product
// stream over 2^tau samples, emitting one rounded, 2x-gain, saturated
// quadrature value per window with a one-cycle valid strobe.
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : pdt_boxcar_avg_if slave (pdt_i/ce_i/restart_i/tau_i in,
//          out_o/valid_o/sat_o/cnt_o out)
module pdt_boxcar_avg #(
   parameter int R       = 14,
   parameter int LAT     = 5,
   parameter int TAU_MAX = 10,
   parameter int OUT_W   = 16,
   parameter int SHR     = 2*R - OUT_W - 1
) (
   input logic              clk,
   input logic              rstn,
   pdt_boxcar_avg_if.slave  bus
);
   localparam int PW    = 2*R;
   localparam int ACC_W = PW + TAU_MAX;
   localparam int TW    = $clog2(TAU_MAX + 1);
   localparam int CW    = TAU_MAX + 1;
   localparam int SW    = $clog2(TAU_MAX + SHR + 1);
   localparam int RW    = ACC_W + 1;

   localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [LAT-1:0]          ce_sr, rs_sr;
   logic                    ce_d, rs_d;
   logic                    started;
   logic [TW-1:0]           tau_q, tau_clamp, tau_eff, tau_used;
   logic signed [ACC_W-1:0] acc, acc_base, acc_nxt, sum_q;
   logic [CW-1:0]           cnt, cnt_base, last_idx;
   logic                    win_start, win_last, sum_v;
   logic [SW-1:0]           shift;
   logic signed [RW-1:0]    half, rnd, res;
   logic signed [OUT_W-1:0] res_out, out_q;
   logic                    res_sat, sat_q, valid_q;

   // Align the control strobes with the multiplier output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ce_sr <= '0;
         rs_sr <= '0;
      end else begin
         ce_sr[0] <= bus.ce_i;
         rs_sr[0] <= bus.restart_i;
         for (int unsigned i = 1; i < LAT; i++) begin
            ce_sr[i] <= ce_sr[i-1];
            rs_sr[i] <= rs_sr[i-1];
         end
      end
   end

   assign ce_d = ce_sr[LAT-1];
   assign rs_d = rs_sr[LAT-1];

   // A window start (reset release or restart) is folded in ahead of the
   // sample update so a coincident sample becomes sample 0 of the new window
   // and is judged against the freshly latched tau.
   always_comb begin
      tau_clamp = (bus.tau_i > TW'(TAU_MAX)) ? TW'(TAU_MAX) : bus.tau_i;
      win_start = rs_d | ~started;
      tau_eff   = win_start ? tau_clamp : tau_q;
      acc_base  = win_start ? '0 : acc;
      cnt_base  = win_start ? '0 : cnt;
      acc_nxt   = acc_base + ACC_W'(bus.pdt_i);
      last_idx  = (CW'(1) << tau_eff) - CW'(1);
      win_last  = (cnt_base == last_idx);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         started  <= 1'b0;
         tau_q    <= '0;
         acc      <= '0;
         cnt      <= '0;
         sum_q    <= '0;
         tau_used <= '0;
         sum_v    <= 1'b0;
      end else begin
         started <= 1'b1;
         sum_v   <= 1'b0;
         if (win_start || (ce_d && win_last))
            tau_q <= tau_clamp;
         if (ce_d) begin
            if (win_last) begin
               sum_q    <= acc_nxt;
               tau_used <= tau_eff;
               sum_v    <= 1'b1;
               acc      <= '0;
               cnt      <= '0;
            end else begin
               acc <= acc_nxt;
               cnt <= cnt_base + CW'(1);
            end
         end else if (win_start) begin
            acc <= '0;
            cnt <= '0;
         end
      end
   end

   // Round half up, arithmetic shift, then clamp to the output range.
   always_comb begin
      shift   = SW'(tau_used) + SW'(SHR);
      half    = RW'(1) <<< (shift - SW'(1));
      rnd     = RW'(sum_q) + half;
      res     = rnd >>> shift;
      res_sat = 1'b0;
      res_out = OUT_W'(res);
      if (res > MAX_V) begin
         res_out = OUT_W'(MAX_V);
         res_sat = 1'b1;
      end else if (res < MIN_V) begin
         res_out = OUT_W'(MIN_V);
         res_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q   <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= sum_v;
         if (sum_v) begin
            out_q <= res_out;
            sat_q <= res_sat;
         end
      end
   end

   assign bus.out_o   = out_q;
   assign bus.sat_o   = sat_q;
   assign bus.valid_o = valid_q;
   assign bus.cnt_o   = cnt;
endmodule

// File: tb/tb_pdt_boxcar_avg.sv
// Self-checking bench for pdt_boxcar_avg: directed scenarios plus a random
// phase, compared every cycle against an event-level reference model.
module tb_pdt_boxcar_avg;
   localparam int R       = 14;
   localparam int LAT     = 5;
   localparam int TAU_MAX = 10;
   localparam int OUT_W   = 16;
   localparam int SHR     = 11;
   localparam int PW      = 2*R;
   localparam int TW      = $clog2(TAU_MAX + 1);

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   pdt_boxcar_avg_if #(.R(R), .TAU_MAX(TAU_MAX), .OUT_W(OUT_W)) bus ();

   pdt_boxcar_avg #(.R(R), .LAT(LAT), .TAU_MAX(TAU_MAX), .OUT_W(OUT_W), .SHR(SHR)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   logic signed [PW-1:0] pdt_sched [int];

   // reference model state
   bit    mh_ce [int];
   bit    mh_rs [int];
   int    m_n, m_cnt, m_tau, m_ptau;
   longint m_acc, m_psum;
   bit    m_pend;
   longint e_out;
   bit    e_valid, e_sat;
   int    e_cnt;

   // observed-result tallies
   int nval;
   logic signed [OUT_W-1:0] last_out;
   logic last_sat;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_cnt = 0; m_tau = 0; m_acc = 0; m_pend = 0;
      e_out = 0; e_valid = 0; e_sat = 0; e_cnt = 0;
   endtask

   function automatic void model_edge();
      bit ced, rsd;
      int tau_c, s;
      longint d, num, r;
      ced = (m_n >= LAT) ? mh_ce[m_n-LAT] : 1'b0;
      rsd = (m_n >= LAT) ? mh_rs[m_n-LAT] : 1'b0;
      e_valid = m_pend;
      if (m_pend) begin
         s   = m_ptau + SHR;
         d   = longint'(1) << s;
         num = m_psum + d / 2;
         r   = num / d;
         if ((num % d != 0) && (num < 0)) r = r - 1;
         if (r > 32767)       begin e_out = 32767;  e_sat = 1; end
         else if (r < -32768) begin e_out = -32768; e_sat = 1; end
         else                 begin e_out = r;      e_sat = 0; end
         m_pend = 0;
      end
      tau_c = (int'(bus.tau_i) > TAU_MAX) ? TAU_MAX : int'(bus.tau_i);
      if (rsd || m_n == 0) begin
         m_acc = 0; m_cnt = 0; m_tau = tau_c;
      end
      if (ced) begin
         m_acc = m_acc + longint'(bus.pdt_i);
         m_cnt = m_cnt + 1;
         if (m_cnt == (1 << m_tau)) begin
            m_pend = 1; m_psum = m_acc; m_ptau = m_tau;
            m_acc = 0; m_cnt = 0; m_tau = tau_c;
         end
      end
      e_cnt = m_cnt;
      mh_ce[m_n] = bus.ce_i;
      mh_rs[m_n] = bus.restart_i;
      m_n++;
   endfunction

   task automatic step();
      logic [31:0] junk;
      junk = $urandom;
      bus.pdt_i = pdt_sched.exists(cyc) ? pdt_sched[cyc] : junk[PW-1:0];
      @(posedge clk);
      model_edge();
      #1;
      chk("valid", bus.valid_o, e_valid);
      chk("cnt",   bus.cnt_o,   e_cnt);
      chk("out",   bus.out_o,   e_out);
      chk("sat",   bus.sat_o,   e_sat);
      if (bus.valid_o === 1'b1) begin
         nval++;
         last_out = bus.out_o;
         last_sat = bus.sat_o;
      end
      cyc++;
      bus.ce_i = 1'b0;
      bus.restart_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic issue(input logic signed [PW-1:0] v, input bit rs);
      bus.ce_i = 1'b1;
      bus.restart_i = rs;
      pdt_sched[cyc+LAT] = v;
      step();
   endtask

   task automatic retau(input int t);
      bus.tau_i = TW'(t);
      bus.restart_i = 1'b1;
      step();
      idle(LAT + 1);
   endtask

   task automatic do_reset(input int n);
      rstn = 1'b0;
      bus.ce_i = 1'b0;
      bus.restart_i = 1'b0;
      #1;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_out",   bus.out_o,   0);
      chk("rst_sat",   bus.sat_o,   0);
      chk("rst_cnt",   bus.cnt_o,   0);
      repeat (n) begin @(posedge clk); cyc++; end
      #4;
      rstn = 1'b1;
      model_reset();
      nval = 0;
   endtask

   function automatic logic signed [PW-1:0] rand_pdt();
      logic [31:0] t;
      t = $urandom;
      case ($urandom_range(0, 9))
         0:       return {1'b0, {(PW-1){1'b1}}};
         1:       return {1'b1, {(PW-1){1'b0}}};
         default: return t[PW-1:0];
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ce_i = 1'b0;
      bus.restart_i = 1'b0;
      bus.pdt_i = '0;
      bus.tau_i = TW'(2);
      model_reset();

      // 1. nominal window of four
      do_reset(2);
      idle(2);
      repeat (4) issue(28'sd1048576, 1'b0);
      idle(LAT + 3);
      chk("t1_count", nval, 1);
      chk("t1_out", last_out, 512);
      chk("t1_sat", last_sat, 0);

      // 2. rounding and sign at tau=0, then back-to-back results
      retau(0);
      nval = 0;
      issue(28'sd3072, 1'b0);   idle(LAT + 1); chk("t2_pos", last_out, 2);
      issue(-28'sd3072, 1'b0);  idle(LAT + 1); chk("t2_neg", last_out, -1);
      issue(-28'sd1024, 1'b0);  idle(LAT + 1); chk("t2_zero", last_out, 0);
      repeat (4) issue(rand_pdt(), 1'b0);
      idle(LAT + 2);
      chk("t2_count", nval, 7);

      // 3. saturation
      nval = 0;
      issue(28'sd134217727, 1'b0); idle(LAT + 1);
      chk("t3_hi", last_out, 32767); chk("t3_hi_sat", last_sat, 1);
      issue(-28'sd134217728, 1'b0); idle(LAT + 1);
      chk("t3_lo", last_out, -32768); chk("t3_lo_sat", last_sat, 1);
      issue(28'sd0, 1'b0); idle(LAT + 1);
      chk("t3_z", last_out, 0); chk("t3_z_sat", last_sat, 0);

      // 4. restart with a coincident sample; tau change lands one window later
      retau(3);
      nval = 0;
      repeat (5) issue(28'sd4194304, 1'b0);
      issue(-28'sd4194304, 1'b1);
      for (int j = 0; j < 7; j++) begin
         if (j == 6) bus.tau_i = TW'(1);
         issue(-28'sd4194304, 1'b0);
      end
      idle(LAT + 2);
      chk("t4_count", nval, 1);
      chk("t4_out", last_out, -2048);
      repeat (2) issue(28'sd4194304, 1'b0);
      idle(LAT + 2);
      chk("t4_count2", nval, 2);
      chk("t4_out2", last_out, 2048);

      // 5. reset with samples still in flight
      retau(2);
      repeat (3) issue(28'sd1048576, 1'b0);
      do_reset(3);
      idle(LAT + 3);
      chk("t5_none", nval, 0);
      repeat (4) issue(-28'sd524288, 1'b0);
      idle(LAT + 2);
      chk("t5_count", nval, 1);
      chk("t5_out", last_out, -256);

      // 6. tau clamp at TAU_MAX
      bus.tau_i = TW'(15);
      do_reset(2);
      repeat (1024) issue(28'sd65536, 1'b0);
      idle(LAT + 2);
      chk("t6_count", nval, 1);
      chk("t6_out", last_out, 32);
      chk("t6_sat", last_sat, 0);
      chk("t6_cnt", bus.cnt_o, 0);

      // 7. random traffic with occasional restarts and tau changes
      retau(1);
      for (int k = 0; k < 500; k++) begin
         if (k % 40 == 0) bus.tau_i = ($urandom_range(0, 7) == 7) ? TW'(12) : TW'($urandom_range(0, 4));
         bus.restart_i = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 99) < 65) begin
            bus.ce_i = 1'b1;
            pdt_sched[cyc+LAT] = rand_pdt();
         end
         if (k == 250) do_reset(2);
         step();
      end
      idle(LAT + 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/pdt_boxcar_avg.md
Name: pdt_boxcar_avg

Overview:
Lock-in demodulation back end. Consumes the signed product stream from the pipelined multiplier (signal × reference) and boxcar-averages it over 2^tau samples. It emits one rounded, 2×-gain, saturated quadrature value per window, with a one-cycle valid strobe. Control strobes are issued alongside the multiplier operands and are internally delayed to line up with the product.

Parameters:
R, 14, operand width of the upstream multiplier; product width is 2R
LAT, 5, upstream multiplier latency in clocks (level+1)
TAU_MAX, 10, maximum log2 window length
OUT_W, 16, output width
SHR, 11, fixed extra right shift (default 2R-OUT_W-1, which gives the lock-in 2× gain)

Ports:
clk  in  1  system clock, all logic rising-edge
rstn  in  1  asynchronous active-low reset
pdt_i  in  2R  two's-complement product from the multiplier
ce_i  in  1  sample-valid, issued in the same cycle as the multiplier operands
restart_i  in  1  abort the current window, issued in the same cycle as the operands
tau_i  in  TW=$clog2(TAU_MAX+1)  log2 window length; values above TAU_MAX clamp to TAU_MAX
out_o  out  OUT_W  signed averaged result
valid_o  out  1  one-cycle strobe when out_o updates
sat_o  out  1  out_o of the current result was saturated
cnt_o  out  TAU_MAX+1  samples accumulated in the current window

Behaviour:
- Reset (rstn=0, async): delay line, accumulator, counter, tau_q, sum register, out_o, valid_o, sat_o and cnt_o all go to 0. Strobes in flight are lost. After reset, tau_q is latched from tau_i on the first edge.
- Alignment: ce_i and restart_i pass through an LAT-flop delay line to give ce_d and rs_d.
  - If ce_i is sampled at edge e, the matching pdt_i is consumed at edge e+LAT.
- Accumulator width: ACC_W = 2R+TAU_MAX, signed. pdt_i is sign-extended.
- Window: the window length is 2^tau_q. tau_q is latched from min(tau_i, TAU_MAX) at the start of each window, i.e. on reset release, on rs_d, and on window completion. Changes to tau_i mid-window take effect at the next window.
- On each ce_d edge:
  - acc <= acc + pdt
  - cnt <= cnt + 1
  - If cnt == 2^tau_q - 1: sum_q <= acc + pdt, acc <= 0, cnt <= 0, and tau_q is relatched.
- Output stage, on the edge after sum_q loads:
  - s = tau_q_used + SHR
  - r = (sum_q + 2^(s-1)) >>> s (round half up, arithmetic shift)
  - out_o = r saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
  - sat_o = 1 if clamping occurred, else 0
  - valid_o = 1 for exactly one cycle
  - Net effect: valid_o rises on edge e+LAT+1, where e is the edge sampling the last ce_i of the window.
- Between results, out_o and sat_o hold their values and valid_o stays 0.
- rs_d: clears acc and cnt and relatches tau_q; the partial window produces no valid_o.
  - If rs_d and ce_d occur together, that sample becomes sample 0 of the new window.
  - A result already in the output stage still issues.
- tau_q=0: every ce_d produces a result. Back-to-back ce_d produces back-to-back valid_o.
- No overflow is possible in acc: |pdt| ≤ 2^(2R-1) and at most 2^TAU_MAX terms.
- cnt_o mirrors cnt.

Test Plan:
1. Nominal: tau_i=2, four ce_i pulses with pdt_i=2^20 aligned LAT later -> sum 2^22, s=13, out_o=512, valid_o high exactly one cycle at e_last+LAT+1, sat_o=0.
2. Rounding and sign: tau_i=0, pdt_i=3072 -> out_o=2; pdt_i=-3072 -> out_o=-1 (0xFFFF); pdt_i=-1024 -> out_o=0.
3. Saturation: tau_i=0, pdt_i=2^27-1 -> out_o=32767, sat_o=1; pdt_i=-2^27 -> out_o=-32768, sat_o=1; next pdt_i=0 -> out_o=0, sat_o=0.
4. Restart and tau change: tau_i=3, 5 samples of 2^22, then restart_i together with the 6th ce_i and tau_i changed to 1 mid-sequence -> no valid_o for the partial window; the next 8 samples of -2^22 give out_o=-2048. tau=1 applies only in the window after that.
5. Reset mid-window: rstn low for 3 cycles after 3 of 4 samples (tau=2), with ce_i pulses still in the delay line -> all outputs 0, in-flight samples discarded; the first valid_o comes only after 4 fresh post-reset samples, with the correct mean.
6. Clamp: TAU_MAX=10, tau_i=15 (TW=4), 1024 samples of 2^16 -> exactly one valid_o after the 1024th sample, out_o=32, cnt_o wraps to 0.
